// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// Holds the architectural widths, the per-entry state enum and the packed
// entry payload used by the entry ring and the top level.
package fetch_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned ILEN       = 32;
    localparam int unsigned INSN_BYTES = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PENDING = 2'd1,
        READY   = 2'd2
    } entry_state_e;

    typedef struct packed {
        entry_state_e      state;
        logic [XLEN-1:0]   pc;
        logic [ILEN-1:0]   insn;
    } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/fetch_entry_ring.sv
// Circular storage of prefetch entries with head (oldest), tail (next to
// allocate) and pend (oldest PENDING) pointers.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           empty every entry and zero all pointers (wins over strobes)
//   alloc/alloc_pc  claim the tail entry as PENDING for alloc_pc
//   fill/fill_insn  oldest PENDING entry becomes READY with fill_insn
//   pop             free the head entry
//   head_entry_c    current head entry (read straight from storage)
//   tail_empty_c    tail entry is EMPTY, i.e. the ring has room
module fetch_entry_ring
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alloc,
    input  logic [XLEN-1:0]   alloc_pc,
    input  logic              fill,
    input  logic [ILEN-1:0]   fill_insn,
    input  logic              pop,
    output fetch_entry_t      head_entry_c,
    output logic              tail_empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] pend;

    // Entry storage and pointers; alloc/fill/pop always touch distinct
    // entries because each requires a different entry state.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            pend <= '0;
        end else begin
            if (alloc) begin
                entries[tail] <= '{state: PENDING, pc: alloc_pc, insn: '0};
                tail          <= tail + PTR_W'(1);
            end
            if (fill) begin
                entries[pend].state <= READY;
                entries[pend].insn  <= fill_insn;
                pend                <= pend + PTR_W'(1);
            end
            if (pop) begin
                entries[head].state <= EMPTY;
                head                <= head + PTR_W'(1);
            end
        end
    end

    assign head_entry_c = entries[head];
    assign tail_empty_c = (entries[tail].state == EMPTY);

endmodule : fetch_entry_ring

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetch addresses to imem,
// collects in-order responses in a prefetch ring and presents {pc, insn}
// to decode. A redirect flushes the ring and discards in-flight responses.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   redirect_valid, redirect_pc       branch redirect (pc[1:0] ignored)
//   imem_req_valid/ready/addr         fetch request channel
//   imem_rsp_valid/data               in-order fetch responses
//   id_valid/ready, id_pc, id_instruction   decode handoff
//   stat_fetched, stat_dropped, stat_stall_cycles
//                                     saturating counters, present only when
//                                     FETCH_STATS_EN is defined
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned    QUEUE_DEPTH     = 4,
    parameter int unsigned    MAX_OUTSTANDING = 2,
    parameter logic [63:0]    RESET_PC        = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [ILEN-1:0]   imem_rsp_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [ILEN-1:0]   id_instruction
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_dropped,
    output logic [31:0]       stat_stall_cycles
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [XLEN-1:0]  fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;

    fetch_entry_t     head_entry_c;
    logic             tail_empty_c;
    logic             req_fire_c;
    logic             rsp_eff_c;
    logic             drop_rsp_c;
    logic             id_fire_c;
    logic             redirect_lsb_unused;

    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Request gating: never during reset or a redirect cycle.
    assign imem_req_valid = !rst && !redirect_valid && tail_empty_c &&
                            (outstanding < CNT_W'(MAX_OUTSTANDING));
    assign imem_req_addr  = fetch_pc;

    assign req_fire_c = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is spurious and ignored.
    assign rsp_eff_c  = imem_rsp_valid && (outstanding != '0);
    assign drop_rsp_c = rsp_eff_c && (drop_cnt != '0);
    assign id_fire_c  = id_valid && id_ready;

    assign id_valid       = (head_entry_c.state == READY);
    assign id_pc          = head_entry_c.pc;
    assign id_instruction = head_entry_c.insn;

    fetch_entry_ring #(
        .DEPTH (QUEUE_DEPTH)
    ) u_ring (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect_valid),
        .alloc        (req_fire_c),
        .alloc_pc     (fetch_pc),
        .fill         (rsp_eff_c && !drop_rsp_c && !redirect_valid),
        .fill_insn    (imem_rsp_data),
        .pop          (id_fire_c && !redirect_valid),
        .head_entry_c (head_entry_c),
        .tail_empty_c (tail_empty_c)
    );

    // Fetch pc and in-flight accounting. On redirect every response still
    // in flight (after this cycle's one) must be discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            outstanding <= outstanding - CNT_W'(rsp_eff_c);
            drop_cnt    <= outstanding - CNT_W'(rsp_eff_c);
        end else begin
            if (req_fire_c) begin
                fetch_pc <= fetch_pc + XLEN'(INSN_BYTES);
            end
            outstanding <= outstanding + CNT_W'(req_fire_c) - CNT_W'(rsp_eff_c);
            if (drop_rsp_c) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_STATS_EN
    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched      <= '0;
            stat_dropped      <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (id_fire_c && (stat_fetched != '1)) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (rsp_eff_c && (drop_rsp_c || redirect_valid) && (stat_dropped != '1)) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
            if (id_valid && !id_ready && (stat_stall_cycles != '1)) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_prefetch_queue

// File: tb/tb_fetch_prefetch_queue.sv
// Self-checking bench for fetch_prefetch_queue: a transaction-level model
// (queue of in-order entries plus in-flight/drop counts) predicts the
// outputs each cycle, and a memory model answers requests with 1-3 cycle
// latency. Directed scenarios precede a randomized run.
module tb_fetch_prefetch_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned MAX_OUT = 2;
    localparam logic [63:0] RST_PC  = 64'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_dropped, stat_stall_cycles;
`endif

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .QUEUE_DEPTH     (DEPTH),
        .MAX_OUTSTANDING (MAX_OUT),
        .RESET_PC        (RST_PC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_pc           (id_pc),
        .id_instruction  (id_instruction)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched      (stat_fetched),
        .stat_dropped      (stat_dropped),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    typedef struct {
        logic [63:0] pc;
        bit          ready;
        logic [31:0] insn;
    } m_ent_t;

    typedef struct {
        int          due;
        logic [63:0] addr;
    } mem_req_t;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    m_ent_t      mq[$];
    int          m_out;
    int          m_drop;
    logic [63:0] m_pc;
    logic [63:0] exp_pop_pc;

    // Memory model and observation logs
    mem_req_t    memq[$];
    int          last_due;
    int          cyc = 0;
    int          first_acc_cyc;
    int          first_valid_cyc;
    int          acc_count;
    logic [63:0] acc_log[$];
    logic [63:0] pop_log[$];

    function automatic logic [31:0] insn_of(input logic [63:0] addr);
        return {addr[17:2], ~addr[17:2]} ^ 32'h1357_9bdf ^ addr[49:18];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        mq.delete();
        memq.delete();
        m_out           = 0;
        m_drop          = 0;
        m_pc            = RST_PC;
        exp_pop_pc      = RST_PC;
        last_due        = cyc;
        first_acc_cyc   = -1;
        first_valid_cyc = -1;
        acc_count       = 0;
        acc_log.delete();
        pop_log.delete();
    endtask

    // Hold reset for n edges, check the idle outputs, then release.
    task automatic do_reset(input int n);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        id_ready       = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_id_valid", id_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_insn", id_instruction, 0);
        rst = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic redir, input logic [63:0] rpc, input logic req_rdy,
                        input logic id_rdy, input int lat);
        logic        rsp_v;
        logic [31:0] rsp_d;
        bit          m_rv, m_iv, acc, pop, rsp;
        int          due;
        m_ent_t      e;
        rsp_v = 1'b0;
        rsp_d = '0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rsp_v = 1'b1;
            rsp_d = insn_of(memq[0].addr);
            memq.delete(0);
        end
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = req_rdy;
        id_ready       = id_rdy;
        imem_rsp_valid = rsp_v;
        imem_rsp_data  = rsp_d;
        #1;
        m_rv = !redir && (mq.size() < DEPTH) && (m_out < MAX_OUT);
        m_iv = (mq.size() > 0) && mq[0].ready;
        check("req_valid", imem_req_valid, m_rv);
        check("id_valid", id_valid, m_iv);
        if (m_rv) check("req_addr", imem_req_addr, m_pc);
        if (m_iv) begin
            check("id_pc", id_pc, mq[0].pc);
            check("id_insn", id_instruction, mq[0].insn);
        end
        // Independent stream checks on what decode actually receives
        if (id_valid && id_ready) begin
            check("pop_pc_seq", id_pc, exp_pop_pc);
            check("pop_insn_mem", id_instruction, insn_of(id_pc));
            exp_pop_pc = id_pc + 64'd4;
            pop_log.push_back(id_pc);
        end
        if (id_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (imem_req_valid && imem_req_ready) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{due: due, addr: imem_req_addr});
            acc_log.push_back(imem_req_addr);
            acc_count++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        // Model update
        acc = m_rv && req_rdy;
        pop = m_iv && id_rdy;
        rsp = rsp_v && (m_out > 0);
        if (redir) begin
            mq.delete();
            m_out      = m_out - (rsp ? 1 : 0);
            m_drop     = m_out;
            m_pc       = {rpc[63:2], 2'b00};
            exp_pop_pc = m_pc;
        end else begin
            if (pop) mq.delete(0);
            if (rsp) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!mq[i].ready) begin
                            e       = mq[i];
                            e.ready = 1'b1;
                            e.insn  = rsp_d;
                            mq[i]   = e;
                            break;
                        end
                    end
                end
            end
            if (acc) begin
                mq.push_back('{pc: m_pc, ready: 1'b0, insn: '0});
                m_pc = m_pc + 64'd4;
            end
            m_out = m_out + (acc ? 1 : 0) - (rsp ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Run with decode ready until a pop is logged or the budget expires.
    task automatic run_until_pop(input string tag, input logic [63:0] exp_pc);
        for (int i = 0; i < 30 && pop_log.size() == 0; i++) step(0, '0, 1, 1, 1);
        check({tag, "_seen"}, 64'(pop_log.size() > 0), 1);
        if (pop_log.size() > 0) check(tag, pop_log[0], exp_pc);
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        do_reset(2);

        // Streaming: always ready, 1-cycle latency
        for (int i = 0; i < 12; i++) step(0, '0, 1, 1, 1);
        check("first_acc_addr", acc_log[0], 64'h0);
        check("first_valid_latency", 64'(first_valid_cyc - first_acc_cyc), 2);
        check("stream_pops", 64'(pop_log.size() >= 8), 1);

        // Decode stalled: queue fills with exactly DEPTH requests
        do_reset(1);
        for (int i = 0; i < 10; i++) step(0, '0, 1, 0, 1);
        check("stall_acc_count", 64'(acc_count), DEPTH);
        #1;
        check("stall_req_valid", imem_req_valid, 0);
        for (int i = 0; i < 40 && pop_log.size() < 4; i++) step(0, '0, 0, 1, 1);
        check("drain_count", 64'(pop_log.size()), 4);
        if (pop_log.size() == 4) check("drain_last_pc", pop_log[3], 64'hC);

        // Redirect with two responses in flight
        do_reset(1);
        step(0, '0, 1, 0, 3);
        step(0, '0, 1, 0, 3);
        step(1, 64'h1002, 1, 0, 1);
        acc_log.delete();
        pop_log.delete();
        run_until_pop("redir_first_pop", 64'h1000);
        check("redir_first_acc", (acc_log.size() > 0) ? acc_log[0] : 64'hdead, 64'h1000);

        // Redirect in the same cycle as a response and an id handshake
        do_reset(1);
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 3);
        step(0, '0, 1, 0, 1);
        step(0, '0, 1, 0, 1);
        pop_log.delete();
        step(1, 64'h2000, 1, 1, 1);
        check("redir_hs_pops", 64'(pop_log.size()), 1);
        if (pop_log.size() == 1) check("redir_hs_pc", pop_log[0], 64'h0);
        pop_log.delete();
        run_until_pop("redir_hs_next_pop", 64'h2000);

        // Randomized traffic with a reset mid-stream
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                for (int j = 0; j < 6; j++) step(0, '0, 1, 0, 1);
                check("mid_rst_has_ready", id_valid, 1);
                do_reset(1);
                step(0, '0, 1, 1, 1);
                check("mid_rst_first_acc", (acc_log.size() > 0) ? acc_log[0] : 64'hdead, RST_PC);
            end
            step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
                 {$urandom(), $urandom()},
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fetch_prefetch_queue

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
- Generates sequential fetch addresses and issues them to the instruction memory over a valid/ready request channel.
- Collects in-order responses into a small prefetch queue and presents {pc, instruction} to decode with a valid/ready handshake.
- Handles branch redirects by flushing the queue and discarding responses still in flight.

Parameters:
- QUEUE_DEPTH, 4, number of queue entries; power of two, minimum 2.
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests, including those marked for drop.
- RESET_PC, 64'h0, fetch address loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- redirect_valid  input  1  branch taken; flush the queue and restart fetch.
- redirect_pc  input  64  new fetch address; bits [1:0] are ignored and treated as zero.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  64  fetch address.
- imem_rsp_valid  input  1  response valid; responses arrive in order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- id_valid  output  1  head entry holds an instruction.
- id_ready  input  1  decode consumes the head entry (low when decode is stalled).
- id_pc  output  64  pc of the head entry.
- id_instruction  output  32  instruction of the head entry.

Behaviour:
- Each entry has state EMPTY, PENDING or READY, plus pc[63:0] and insn[31:0]. Head, tail and pending pointers wrap modulo QUEUE_DEPTH.
- Reset: fetch_pc=RESET_PC; all entries EMPTY; pointers, outstanding and drop_cnt = 0. Outputs during and after reset until state changes: imem_req_valid=0, id_valid=0, id_pc=0, id_instruction=0.
- imem_req_valid = !redirect_valid && tail entry EMPTY && outstanding<MAX_OUTSTANDING.
- imem_req_addr = fetch_pc. Address is stable while valid is held; retraction is permitted only in a redirect cycle.
- Request accepted (valid&&ready):
  - tail entry becomes PENDING with pc=fetch_pc;
  - tail advances;
  - fetch_pc += 4, with 64-bit wrap;
  - outstanding increments.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise the oldest PENDING entry becomes READY with insn=imem_rsp_data.
  - In both cases outstanding decrements.
- A response never arrives with outstanding=0. Any such response is ignored.
- id_valid = head entry READY. id_pc and id_instruction come from the head entry (registered state only). An id handshake frees the head entry and advances head.
- Latency: request accepted in cycle N, response in cycle N+k (k≥1), id_valid earliest in cycle N+k+1. There is no response-to-output bypass.
- Redirect, which takes priority over all other updates in its cycle:
  - all entries become EMPTY and all pointers reset to 0;
  - fetch_pc = {redirect_pc[63:2],2'b00};
  - drop_cnt = outstanding minus (1 if a response arrives this cycle), plus (drop_cnt handling for that response);
  - an id handshake in the same cycle counts as consumed.
- After a redirect, fetch restarts in the next cycle. New requests may issue while drop_cnt>0; ordering guarantees the dropped responses come first.
- Simultaneous accept, response and pop in one cycle are all applied; the occupancy arithmetic must remain exact.
- Full queue: no request issues. Decode stalled (id_ready=0): the queue fills, then requests stop. Queue empty: id_valid=0.

Optional Feature:
- FETCH_STATS_EN: adds three 32-bit saturating outputs, all cleared on rst:
  - stat_fetched: incremented on every id handshake;
  - stat_dropped: incremented on every discarded response;
  - stat_stall_cycles: incremented on cycles with id_valid && !id_ready.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Shared package fetch_pkg holds:
  - XLEN=64, ILEN=32, INSN_BYTES=4;
  - typedef entry_state_e {EMPTY, PENDING, READY};
  - typedef fetch_entry_t {state, pc, insn}.
- One natural sub-module, fetch_entry_ring. It holds entry storage and the head/tail/pending pointers. It exposes alloc, fill, pop and flush strobes.
- The top level keeps fetch_pc, outstanding, drop_cnt and the handshake logic.

Test Plan:
- Reset, then imem always ready with 1-cycle latency and id_ready=1 -> requests for addresses 0x0,0x4,0x8…; id_valid first seen 2 cycles after the first accept; id_pc increments by 4 every cycle.
- id_ready=0 for 10 cycles, QUEUE_DEPTH=4 -> exactly 4 requests accepted and then imem_req_valid=0. Releasing id_ready drains pcs 0x0..0xC in order with no loss.
- Redirect to 0x1002 with 2 responses in flight -> the next 2 responses are dropped; the next request address is 0x1000; the first id_pc after the redirect is 0x1000.
- Redirect in the same cycle as a response and an id handshake -> the response is neither dropped twice nor enqueued; drop_cnt=outstanding-1; the handshake completes.
- imem_req_ready randomly low, latency 1–3 -> the output pc sequence is contiguous and instructions match a memory model.
- rst asserted mid-stream with entries READY -> the next cycle shows id_valid=0, imem_req_valid=0, and fetch resumes at RESET_PC.
